// File: rtl/port_bridge_if.sv
// port_bridge_if
// Bundles the CPU-side port strobes and both external-device handshakes of
// the port bridge so that a single interface carries them.
//   CPU side    : port_write_in, port_read_in, PORT_in, port_data_in,
//                 port_data_out, stall_out
//   OUT device  : ext_out_valid_out, ext_out_ready_in, ext_out_port_out,
//                 ext_out_data_out
//   IN device   : ext_in_valid_in, ext_in_ready_out, ext_in_port_in,
//                 ext_in_data_in
//   Status      : in_fresh_out, fifo_count_out
// The slave modport is the bridge itself; the master modport is whatever
// drives it (memory stage plus external devices, or a bench).
interface port_bridge_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          port_write_in;
  logic          port_read_in;
  logic [3:0]    PORT_in;
  logic [15:0]   port_data_in;
  logic [15:0]   port_data_out;
  logic          stall_out;

  logic          ext_out_valid_out;
  logic          ext_out_ready_in;
  logic [3:0]    ext_out_port_out;
  logic [15:0]   ext_out_data_out;

  logic          ext_in_valid_in;
  logic          ext_in_ready_out;
  logic [3:0]    ext_in_port_in;
  logic [15:0]   ext_in_data_in;

  logic [15:0]   in_fresh_out;
  logic [CW-1:0] fifo_count_out;

  modport slave (
    input  port_write_in, port_read_in, PORT_in, port_data_in,
    output port_data_out, stall_out,
    output ext_out_valid_out, ext_out_port_out, ext_out_data_out,
    input  ext_out_ready_in,
    input  ext_in_valid_in, ext_in_port_in, ext_in_data_in,
    output ext_in_ready_out,
    output in_fresh_out, fifo_count_out
  );

  modport master (
    output port_write_in, port_read_in, PORT_in, port_data_in,
    input  port_data_out, stall_out,
    input  ext_out_valid_out, ext_out_port_out, ext_out_data_out,
    output ext_out_ready_in,
    output ext_in_valid_in, ext_in_port_in, ext_in_data_in,
    input  ext_in_ready_out,
    input  in_fresh_out, fifo_count_out
  );
endinterface

// File: rtl/port_bridge.sv
// port_bridge
// Device-side responder for the processor's 16 I/O ports.
//   OUT direction: CPU port writes {port, data} are queued in a show-ahead
//   FIFO of DEPTH entries and handed to an external device over
//   valid/ready. stall_out asks the CPU to hold its write while full.
//   IN direction: the device writes a 16-entry input register file over
//   valid/ready; the CPU reads it combinationally. A per-port fresh bit
//   marks ports written but not yet read.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears every register
//   bus   - port_bridge_if.slave carrying CPU and device signals
// Parameters:
//   DEPTH     - OUT FIFO entries, power of two, at least 2
//   OVERWRITE - 1: device may overwrite an unread port,
//               0: device is held off until the CPU reads the port
module port_bridge #(
  parameter int DEPTH     = 4,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  port_bridge_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    port_mem [DEPTH];
  logic [15:0]   data_mem [DEPTH];

  logic [15:0]   in_reg [16];
  logic [15:0]   in_fresh;

  logic          full;
  logic          push;
  logic          pop;
  logic          head_valid;
  logic          in_ready;
  logic          in_accept;

  // Full looks only at the registered count, so a pop in the same cycle
  // never frees a slot for the write; this keeps ext_out_ready_in out of
  // the stall path.
  assign full       = (count == CW'(DEPTH));
  assign head_valid = (count != '0);
  assign push       = bus.port_write_in & ~full;
  assign pop        = head_valid & bus.ext_out_ready_in;

  // Ready depends only on the target port's fresh bit, never on valid.
  assign in_ready  = ~reset & (OVERWRITE | ~in_fresh[bus.ext_in_port_in]);
  assign in_accept = bus.ext_in_valid_in & in_ready;

  // OUT FIFO storage and pointers; pointers wrap naturally since DEPTH is
  // a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        port_mem[i] <= 4'd0;
        data_mem[i] <= 16'd0;
      end
    end else begin
      if (push) begin
        port_mem[wr_ptr] <= bus.PORT_in;
        data_mem[wr_ptr] <= bus.port_data_in;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Input register file. The set of the fresh bit is written after the
  // clear so that a device write and a CPU read of the same port in one
  // cycle leave the port marked fresh with the new data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_fresh <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        in_reg[i] <= 16'd0;
      end
    end else begin
      if (bus.port_read_in) begin
        in_fresh[bus.PORT_in] <= 1'b0;
      end
      if (in_accept) begin
        in_reg[bus.ext_in_port_in]   <= bus.ext_in_data_in;
        in_fresh[bus.ext_in_port_in] <= 1'b1;
      end
    end
  end

  assign bus.stall_out         = bus.port_write_in & full;
  assign bus.ext_out_valid_out = head_valid;
  assign bus.ext_out_port_out  = head_valid ? port_mem[rd_ptr] : 4'd0;
  assign bus.ext_out_data_out  = head_valid ? data_mem[rd_ptr] : 16'd0;
  assign bus.ext_in_ready_out  = in_ready;
  assign bus.port_data_out     = bus.port_read_in ? in_reg[bus.PORT_in] : 16'd0;
  assign bus.in_fresh_out      = in_fresh;
  assign bus.fifo_count_out    = count;
endmodule

// File: tb/tb_port_bridge.sv
// tb_port_bridge
// Directed bench for port_bridge. Instance dut_ow uses OVERWRITE = 1,
// instance dut_bp uses OVERWRITE = 0; both have DEPTH = 4 and share clk
// and reset. Inputs change 2 time units after a rising edge and outputs
// are sampled 1 unit later, well away from the next edge.
module tb_port_bridge;
  logic clk;
  logic reset;
  int   check_count;
  int   pass_count;

  port_bridge_if #(.DEPTH(4)) bus_ow ();
  port_bridge_if #(.DEPTH(4)) bus_bp ();

  port_bridge #(.DEPTH(4), .OVERWRITE(1'b1)) dut_ow (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_ow.slave)
  );

  port_bridge #(.DEPTH(4), .OVERWRITE(1'b0)) dut_bp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_bp.slave)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Drives the CPU side of dut_ow.
  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic [3:0] port, input logic [15:0] data);
    bus_ow.port_write_in = wr;
    bus_ow.port_read_in  = rd;
    bus_ow.PORT_in       = port;
    bus_ow.port_data_in  = data;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0);
    bus_ow.ext_out_ready_in = 1'b0;
    bus_ow.ext_in_valid_in  = 1'b0;
    bus_ow.ext_in_port_in   = 4'd0;
    bus_ow.ext_in_data_in   = 16'd0;
    bus_bp.port_write_in    = 1'b0;
    bus_bp.port_read_in     = 1'b0;
    bus_bp.PORT_in          = 4'd0;
    bus_bp.port_data_in     = 16'd0;
    bus_bp.ext_out_ready_in = 1'b0;
    bus_bp.ext_in_valid_in  = 1'b0;
    bus_bp.ext_in_port_in   = 4'd0;
    bus_bp.ext_in_data_in   = 16'd0;

    // Reset state
    nextCycle();
    nextCycle();
    #1;
    checkOutput("rst_in_ready", bus_ow.ext_in_ready_out, 0);
    checkOutput("rst_valid", bus_ow.ext_out_valid_out, 0);
    checkOutput("rst_count", bus_ow.fifo_count_out, 0);
    checkOutput("rst_fresh", bus_ow.in_fresh_out, 0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", bus_ow.ext_in_ready_out, 1);
    nextCycle();

    // Single write to port 3, then pop
    applyStimulus(1'b1, 1'b0, 4'd3, 16'hA5A5);
    #1;
    checkOutput("t1_stall", bus_ow.stall_out, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0);
    #1;
    checkOutput("t1_valid", bus_ow.ext_out_valid_out, 1);
    checkOutput("t1_port", bus_ow.ext_out_port_out, 3);
    checkOutput("t1_data", bus_ow.ext_out_data_out, 16'hA5A5);
    checkOutput("t1_count", bus_ow.fifo_count_out, 1);
    bus_ow.ext_out_ready_in = 1'b1;
    nextCycle();
    bus_ow.ext_out_ready_in = 1'b0;
    #1;
    checkOutput("t1_valid_after_pop", bus_ow.ext_out_valid_out, 0);
    checkOutput("t1_count_after_pop", bus_ow.fifo_count_out, 0);

    // Fill to DEPTH, stall on the fifth write
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 4'(k), 16'(k));
      #1;
      checkOutput("t2_no_stall", bus_ow.stall_out, 0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 4'd5, 16'd5);
    #1;
    checkOutput("t2_stall", bus_ow.stall_out, 1);
    checkOutput("t2_count_full", bus_ow.fifo_count_out, 4);
    nextCycle();
    bus_ow.ext_out_ready_in = 1'b1;
    #1;
    checkOutput("t2_stall_with_pop", bus_ow.stall_out, 1);
    checkOutput("t2_head_first", bus_ow.ext_out_data_out, 1);
    nextCycle();
    bus_ow.ext_out_ready_in = 1'b0;
    #1;
    checkOutput("t2_count_after_pop", bus_ow.fifo_count_out, 3);
    checkOutput("t2_stall_released", bus_ow.stall_out, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0);
    #1;
    checkOutput("t2_count_refill", bus_ow.fifo_count_out, 4);
    bus_ow.ext_out_ready_in = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      #1;
      checkOutput("t2_drain_data", bus_ow.ext_out_data_out, k);
      checkOutput("t2_drain_port", bus_ow.ext_out_port_out, k);
      nextCycle();
    end
    bus_ow.ext_out_ready_in = 1'b0;
    #1;
    checkOutput("t2_empty", bus_ow.fifo_count_out, 0);
    checkOutput("t2_empty_data", bus_ow.ext_out_data_out, 0);

    // Streaming with ready held high: occupancy stays at one, pointers wrap
    bus_ow.ext_out_ready_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 4'(k), 16'(100 + k));
      #1;
      if (k > 0) begin
        checkOutput("t3_data", bus_ow.ext_out_data_out, 100 + k - 1);
        checkOutput("t3_count", bus_ow.fifo_count_out, 1);
        checkOutput("t3_stall", bus_ow.stall_out, 0);
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0);
    #1;
    checkOutput("t3_last", bus_ow.ext_out_data_out, 109);
    nextCycle();
    bus_ow.ext_out_ready_in = 1'b0;
    #1;
    checkOutput("t3_drained", bus_ow.fifo_count_out, 0);

    // Device write to port 7, CPU read of port 7
    bus_ow.ext_in_valid_in = 1'b1;
    bus_ow.ext_in_port_in  = 4'd7;
    bus_ow.ext_in_data_in  = 16'h1234;
    #1;
    checkOutput("t4_ready", bus_ow.ext_in_ready_out, 1);
    nextCycle();
    bus_ow.ext_in_valid_in = 1'b0;
    #1;
    checkOutput("t4_fresh_set", bus_ow.in_fresh_out, 16'h0080);
    applyStimulus(1'b0, 1'b1, 4'd7, 16'd0);
    #1;
    checkOutput("t4_read", bus_ow.port_data_out, 16'h1234);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0);
    #1;
    checkOutput("t4_fresh_clear", bus_ow.in_fresh_out, 0);
    checkOutput("t4_idle_read", bus_ow.port_data_out, 0);

    // Overwrite allowed on dut_ow: ready stays high on an unread port
    bus_ow.ext_in_valid_in = 1'b1;
    bus_ow.ext_in_port_in  = 4'd0;
    bus_ow.ext_in_data_in  = 16'h0011;
    nextCycle();
    bus_ow.ext_in_data_in  = 16'h0022;
    #1;
    checkOutput("t5_ow_ready", bus_ow.ext_in_ready_out, 1);
    nextCycle();
    bus_ow.ext_in_valid_in = 1'b0;
    applyStimulus(1'b0, 1'b1, 4'd0, 16'd0);
    #1;
    checkOutput("t5_ow_data", bus_ow.port_data_out, 16'h0022);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0);

    // Backpressure on dut_bp
    bus_bp.ext_in_valid_in = 1'b1;
    bus_bp.ext_in_port_in  = 4'd2;
    bus_bp.ext_in_data_in  = 16'h1111;
    #1;
    checkOutput("t6_first_ready", bus_bp.ext_in_ready_out, 1);
    nextCycle();
    bus_bp.ext_in_data_in = 16'h2222;
    #1;
    checkOutput("t6_blocked", bus_bp.ext_in_ready_out, 0);
    checkOutput("t6_fresh", bus_bp.in_fresh_out, 16'h0004);
    nextCycle();
    bus_bp.port_read_in = 1'b1;
    bus_bp.PORT_in      = 4'd2;
    #1;
    checkOutput("t6_still_blocked", bus_bp.ext_in_ready_out, 0);
    checkOutput("t6_read_first", bus_bp.port_data_out, 16'h1111);
    nextCycle();
    bus_bp.port_read_in = 1'b0;
    #1;
    checkOutput("t6_unblocked", bus_bp.ext_in_ready_out, 1);
    nextCycle();
    bus_bp.ext_in_valid_in = 1'b0;
    #1;
    checkOutput("t6_fresh_again", bus_bp.in_fresh_out, 16'h0004);
    bus_bp.port_read_in = 1'b1;
    #1;
    checkOutput("t6_read_second", bus_bp.port_data_out, 16'h2222);
    nextCycle();
    // Same-cycle device write and CPU read of port 2
    bus_bp.ext_in_valid_in = 1'b1;
    bus_bp.ext_in_data_in  = 16'hBEEF;
    #1;
    checkOutput("t6_same_ready", bus_bp.ext_in_ready_out, 1);
    checkOutput("t6_same_old", bus_bp.port_data_out, 16'h2222);
    nextCycle();
    bus_bp.ext_in_valid_in = 1'b0;
    bus_bp.port_read_in    = 1'b0;
    #1;
    checkOutput("t6_same_fresh", bus_bp.in_fresh_out, 16'h0004);
    bus_bp.port_read_in = 1'b1;
    #1;
    checkOutput("t6_same_new", bus_bp.port_data_out, 16'hBEEF);
    nextCycle();
    bus_bp.port_read_in = 1'b0;

    // Asynchronous reset mid-handshake
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 4'(k), 16'(16'h0300 + k));
      bus_ow.ext_in_valid_in = 1'b1;
      bus_ow.ext_in_port_in  = (k == 0) ? 4'd0 : 4'd7;
      bus_ow.ext_in_data_in  = 16'h7777;
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0);
    bus_ow.ext_in_valid_in = 1'b0;
    #1;
    checkOutput("t7_pre_count", bus_ow.fifo_count_out, 3);
    checkOutput("t7_pre_fresh", bus_ow.in_fresh_out, 16'h0081);
    bus_ow.ext_out_ready_in = 1'b1;
    bus_ow.ext_in_valid_in  = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'd7, 16'h4444);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t7_rst_valid", bus_ow.ext_out_valid_out, 0);
    checkOutput("t7_rst_count", bus_ow.fifo_count_out, 0);
    checkOutput("t7_rst_fresh", bus_ow.in_fresh_out, 0);
    checkOutput("t7_rst_stall", bus_ow.stall_out, 0);
    checkOutput("t7_rst_in_ready", bus_ow.ext_in_ready_out, 0);
    checkOutput("t7_rst_read", bus_ow.port_data_out, 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0);
    bus_ow.ext_out_ready_in = 1'b0;
    bus_ow.ext_in_valid_in  = 1'b0;
    nextCycle();
    reset = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 1'b1, 4'd0, 16'd0);
    #1;
    checkOutput("t7_read_p0", bus_ow.port_data_out, 0);
    applyStimulus(1'b0, 1'b1, 4'd7, 16'd0);
    #1;
    checkOutput("t7_read_p7", bus_ow.port_data_out, 0);
    checkOutput("t7_post_valid", bus_ow.ext_out_valid_out, 0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
